// File: rtl/adaptive_filter_tdm.sv
// adaptive_filter_tdm: NUM_CH-way interleaved FIR + feedback filter
// with two coefficient banks, flushing mode switch, saturation, backpressure.
module adaptive_filter_tdm #(
  parameter int WL     = 14,
  parameter int FL     = 6,
  parameter int CWL    = 10,
  parameter int CFL    = 8,
  parameter int TAPS   = 5,
  parameter int NUM_CH = 4,
  localparam int CHW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int AW    = $clog2(TAPS)
) (
  input  logic           clk,
  input  logic           arst_n,
  input  logic [WL-1:0]  s_tdata,
  input  logic [CHW-1:0] s_tchan,
  input  logic           s_tvalid,
  output logic           s_tready,
  input  logic           mode_req,
  output logic           mode_cur,
  input  logic           coef_we,
  input  logic           coef_bank,
  input  logic [AW-1:0]  coef_addr,
  input  logic [CWL-1:0] coef_wdata,
  output logic           coef_err,
  output logic [WL-1:0]  m_tdata,
  output logic [CHW-1:0] m_tchan,
  output logic           m_tvalid,
  input  logic           m_tready,
  output logic           sat,
  output logic           busy
);

  localparam int PW   = WL + CWL;
  localparam int ACCW = WL + CWL + $clog2(TAPS);
  localparam int YW   = ACCW + 2;
  localparam int SH   = (FL + CFL) - FL;
  localparam logic signed [YW-1:0] YMAX = YW'((2 ** (WL - 1)) - 1);
  localparam logic signed [YW-1:0] YMIN = YW'(-(2 ** (WL - 1)));

  typedef enum logic [1:0] {
    ST_INIT, ST_RUN, ST_DRAIN, ST_FLUSH
  } state_t;

  state_t state_q, state_d;
  logic   mode_q, mode_d;

  logic signed [CWL-1:0] coef_q [2][TAPS];
  logic signed [CWL-1:0] coef_d [2][TAPS];
  logic signed [WL-1:0]  hist_q [NUM_CH][TAPS-1];
  logic signed [WL-1:0]  hist_d [NUM_CH][TAPS-1];
  logic signed [WL-1:0]  fb_q [NUM_CH];
  logic signed [WL-1:0]  fb_d [NUM_CH];

  logic signed [WL-1:0]  win_q [TAPS];
  logic signed [WL-1:0]  win_d [TAPS];
  logic                  v1_q, v1_d;
  logic [CHW-1:0]        ch1_q, ch1_d;

  logic signed [ACCW-1:0] acc_q, acc_d;
  logic                   v2_q, v2_d;
  logic [CHW-1:0]         ch2_q, ch2_d;

  logic signed [WL-1:0]  y_q, y_d;
  logic                  sat_q, sat_d;
  logic                  v3_q, v3_d;
  logic [CHW-1:0]        ch3_q, ch3_d;
  logic                  err_q, err_d;

  logic adv, take, empty;
  logic signed [PW-1:0]   prod_c;
  logic signed [ACCW-1:0] acc_c;
  logic signed [YW-1:0]   fb_al, sum_c, rnd_c;
  logic signed [WL-1:0]   y_c;
  logic                   sat_c;

  assign adv      = !v3_q || m_tready;
  assign s_tready = adv && (state_q == ST_RUN);
  assign take     = s_tvalid && s_tready;
  assign empty    = !v1_q && !v2_q && !v3_q;

  assign mode_cur = mode_q;
  assign busy     = (state_q == ST_DRAIN) || (state_q == ST_FLUSH);
  assign coef_err = err_q;
  assign m_tdata  = y_q;
  assign m_tchan  = ch3_q;
  assign m_tvalid = v3_q;
  assign sat      = sat_q;

  // S2 math: full-precision dot product of the window with the active bank
  always_comb begin
    acc_c  = '0;
    prod_c = '0;
    for (int k = 0; k < TAPS; k++) begin
      prod_c = PW'(win_q[k]) * PW'(coef_q[mode_q][k]);
      acc_c  = acc_c + ACCW'(prod_c);
    end
  end

  // S3 math: add aligned feedback, round half-up, clip to output range
  always_comb begin
    fb_al = '0;
    if (mode_q) begin
      fb_al = YW'(fb_q[ch2_q]) <<< SH;
    end
    sum_c = YW'(acc_q) + fb_al;
    rnd_c = (sum_c + (YW'(1) <<< (SH - 1))) >>> SH;
    y_c   = rnd_c[WL-1:0];
    sat_c = 1'b0;
    if (rnd_c > YMAX) begin
      y_c   = YMAX[WL-1:0];
      sat_c = 1'b1;
    end else if (rnd_c < YMIN) begin
      y_c   = YMIN[WL-1:0];
      sat_c = 1'b1;
    end
  end

  // Pipeline advance, per-channel history/feedback, flush, coef writes
  always_comb begin
    hist_d = hist_q;
    fb_d   = fb_q;
    coef_d = coef_q;
    win_d  = win_q;
    v1_d   = v1_q;
    ch1_d  = ch1_q;
    acc_d  = acc_q;
    v2_d   = v2_q;
    ch2_d  = ch2_q;
    y_d    = y_q;
    sat_d  = sat_q;
    v3_d   = v3_q;
    ch3_d  = ch3_q;
    err_d  = 1'b0;
    if (adv) begin
      v1_d = take;
      v2_d = v1_q;
      v3_d = v2_q;
      if (take) begin
        ch1_d    = s_tchan;
        win_d[0] = s_tdata;
        for (int k = 1; k < TAPS; k++) begin
          win_d[k] = hist_q[s_tchan][k-1];
        end
        hist_d[s_tchan][0] = s_tdata;
        for (int k = 1; k < TAPS - 1; k++) begin
          hist_d[s_tchan][k] = hist_q[s_tchan][k-1];
        end
      end
      if (v1_q) begin
        acc_d = acc_c;
        ch2_d = ch1_q;
      end
      if (v2_q) begin
        y_d   = y_c;
        sat_d = sat_c;
        ch3_d = ch2_q;
        if (mode_q) begin
          fb_d[ch2_q] = y_c;
        end
      end
    end
    if (state_q == ST_FLUSH) begin
      for (int c = 0; c < NUM_CH; c++) begin
        fb_d[c] = '0;
        for (int k = 0; k < TAPS - 1; k++) begin
          hist_d[c][k] = '0;
        end
      end
    end
    if (coef_we) begin
      if (coef_bank == mode_q || int'(coef_addr) >= TAPS) begin
        err_d = 1'b1;
      end else begin
        coef_d[coef_bank][coef_addr] = coef_wdata;
      end
    end
  end

  // Mode-switch sequencing: stop intake, drain, flush, swap bank
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    unique case (state_q)
      ST_INIT:  state_d = ST_RUN;
      ST_RUN: begin
        if (mode_req != mode_q) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (empty) begin
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        mode_d  = mode_req;
        state_d = ST_RUN;
      end
      default:  state_d = ST_INIT;
    endcase
  end

  // State registers; reset clears everything including coefficients
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= ST_INIT;
      mode_q  <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        for (int k = 0; k < TAPS; k++) begin
          coef_q[b][k] <= '0;
        end
      end
      for (int c = 0; c < NUM_CH; c++) begin
        fb_q[c] <= '0;
        for (int k = 0; k < TAPS - 1; k++) begin
          hist_q[c][k] <= '0;
        end
      end
      for (int k = 0; k < TAPS; k++) begin
        win_q[k] <= '0;
      end
      v1_q  <= 1'b0;
      ch1_q <= '0;
      acc_q <= '0;
      v2_q  <= 1'b0;
      ch2_q <= '0;
      y_q   <= '0;
      sat_q <= 1'b0;
      v3_q  <= 1'b0;
      ch3_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      coef_q  <= coef_d;
      fb_q    <= fb_d;
      hist_q  <= hist_d;
      win_q   <= win_d;
      v1_q    <= v1_d;
      ch1_q   <= ch1_d;
      acc_q   <= acc_d;
      v2_q    <= v2_d;
      ch2_q   <= ch2_d;
      y_q     <= y_d;
      sat_q   <= sat_d;
      v3_q    <= v3_d;
      ch3_q   <= ch3_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: doc/adaptive_filter_tdm.md
Name: adaptive_filter_tdm

Overview:
- Parametrised, time-multiplexed successor to the single-channel differentiator/integrator filter.
- Serves NUM_CH interleaved channels with a TAPS-deep FIR section plus an optional first-order feedback (integrator) path.
- Holds two runtime-writable coefficient banks: bank 0 is the differentiator, bank 1 is the integrator.
- Sits between the sample-stream source and downstream DSP, with AXI-Stream-style valid/ready on both sides.
- Adds three behaviours the previous filter lacked: a safe mode switch with state flush, output saturation, and backpressure.

Parameters:
- WL, 14, sample/output word length (signed)
- FL, 6, sample/output fractional bits
- CWL, 10, coefficient word length (signed)
- CFL, 8, coefficient fractional bits
- TAPS, 5, FIR taps per bank (>=2)
- NUM_CH, 4, interleaved channels (>=1)

Ports:
- clk  in  1  clock
- arst_n  in  1  asynchronous active-low reset
- s_tdata  in  WL  input sample, Q(WL-FL).FL
- s_tchan  in  clog2(NUM_CH) (min 1)  channel of s_tdata
- s_tvalid  in  1  input valid
- s_tready  out  1  input ready
- mode_req  in  1  requested mode: 0 = differentiator, 1 = integrator
- mode_cur  out  1  active mode
- coef_we  in  1  coefficient write strobe
- coef_bank  in  1  target bank
- coef_addr  in  clog2(TAPS)  tap index
- coef_wdata  in  CWL  coefficient, Q(CWL-CFL).CFL
- coef_err  out  1  one-cycle pulse: write was rejected
- m_tdata  out  WL  output sample
- m_tchan  out  clog2(NUM_CH) (min 1)  channel of m_tdata
- m_tvalid  out  1  output valid
- m_tready  in  1  output ready
- sat  out  1  m_tdata was saturated (qualified by m_tvalid)
- busy  out  1  mode switch in progress

Behaviour:
Reset (arst_n low, asynchronous):
- All outputs 0; mode_cur = 0.
- Delay lines, feedback registers and both coefficient banks cleared.
- FSM enters RUN one cycle after arst_n deasserts (s_tready = 0 during that cycle).
- Reset asserted mid-stream discards all in-flight data.

Handshake and pipeline:
- adv = !m_tvalid || m_tready.
- s_tready = adv && state == RUN.
- A sample is accepted when s_tvalid && s_tready.
- Fixed latency: 3 clk from accept to m_tvalid, with no stalls.
- Stalls freeze all stages; no sample is lost or duplicated.
- m_tdata/m_tchan/sat are held stable while m_tvalid && !m_tready.

Pipeline stages:
- S1: register the sample; shift it into hist[ch], a per-channel TAPS-1 deep delay line, on accept only.
- S2: acc = sum over k of coef[mode_cur][k] * x[n-k], computed at full precision.
  - x[n] is the S1 sample, x[n-1..n-TAPS+1] come from hist.
  - Accumulator width: WL+CWL+clog2(TAPS) bits, FL+CFL fractional bits.
- S3, mode 1: y = acc + fb[ch], with fb aligned to FL+CFL.
- S3, mode 0: y = acc.
- S3 output: round half-up to FL bits, then saturate to [-2^(WL-1), 2^(WL-1)-1].
  - sat = 1 when clipped.
  - fb[ch] is updated with the saturated output at S3 advance, in mode 1 only.
  - Back-to-back samples on the same channel therefore see the correct fb.

Mode switch FSM (RUN, DRAIN, FLUSH):
- RUN -> DRAIN when mode_req != mode_cur: s_tready = 0, busy = 1.
- DRAIN -> FLUSH once the pipeline is empty and the last output has been accepted.
- FLUSH lasts exactly 1 clk: clear hist and fb for all channels; mode_cur <= mode_req.
- FLUSH -> RUN.
- mode_req toggling back during DRAIN: the switch still completes to the value of mode_req sampled in FLUSH. If that value equals mode_cur, only the flush happens.

Coefficient writes:
- Accepted any cycle when coef_bank != mode_cur.
- Writes to the active bank are ignored and pulse coef_err the next cycle.
- A coef_addr >= TAPS is ignored and pulses coef_err.
- A write in the same cycle as FLUSH is checked against the pre-switch mode_cur.

Test Plan:
- Differentiator, NUM_CH=1, TAPS=5: bank0 = {256, -256, 0, 0, 0} (+1.0, -1.0); ch0 raw inputs 64, 128, 192 -> outputs 64, 64, 64; latency 3 clk each; sat = 0.
- Integrator: bank1 = {256, 0, 0, 0, 0}, mode_req = 1, wait for busy to fall; ch0 inputs 32 x4 -> outputs 32, 64, 96, 128.
- Saturation in integrator mode: inputs 8000, 8000 -> outputs 8000 (sat = 0), then 8191 (sat = 1); input -8192 x2 -> second output -8192 with sat = 1.
- Interleaving, integrator mode: ch0 = 10, ch1 = 20, ch0 = 10, ch1 = 20 -> 10, 20, 20, 40, with m_tchan = 0, 1, 0, 1.
- Backpressure: stream 8 samples with m_tready low for 5 cycles mid-stream -> s_tready low within 1 clk of the stall; all 8 outputs in order with correct values; m_tdata stable while stalled.
- Mode switch and reset:
  - Toggle mode_req mid-stream -> busy high; no accept until drained; fb cleared (first integrator output equals its input).
  - Write to the active bank -> coef_err = 1 and coefficients unchanged.
  - Assert arst_n low mid-stream -> all outputs 0 immediately; mode_cur = 0.
